// File: rtl/sound_request_arbiter_if.sv
// Signal bundle between game logic / audio player and sound_request_arbiter.
// slave = arbiter side, master = game logic and player side.
interface sound_request_arbiter_if #(
    parameter int NUM_CH = 8
);
    localparam int CODE_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] event_req;
    logic [NUM_CH-1:0] ch_enable;
    logic              play_ready;
    logic              play_done;
    logic              play_valid;
    logic [CODE_W-1:0] play_code;
    logic              busy;
    logic [NUM_CH-1:0] pending;
    logic              play_abort;

    modport slave (
        input  event_req, ch_enable, play_ready, play_done,
        output play_valid, play_code, busy, pending, play_abort
    );

    modport master (
        output event_req, ch_enable, play_ready, play_done,
        input  play_valid, play_code, busy, pending, play_abort
    );
endinterface

// File: rtl/sound_request_arbiter.sv
// Edge-detects NUM_CH event lines, queues them and grants one at a time to the audio player,
// then holds it for HOLD_CYCLES. Define SOUND_PREEMPT_EN to let higher-priority requests cut a hold.
module sound_request_arbiter #(
    parameter int NUM_CH      = 8,
    parameter int HOLD_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    sound_request_arbiter_if.slave bus
);
    localparam int CODE_W  = $clog2(NUM_CH);
    localparam int TIMER_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [NUM_CH-1:0]  r_req_q;
    logic [NUM_CH-1:0]  r_pending;
    logic [CODE_W-1:0]  r_code;
    logic [TIMER_W-1:0] r_timer;

    logic [NUM_CH-1:0]  w_rise;
    logic [NUM_CH-1:0]  w_clear;
    logic [CODE_W-1:0]  w_lowest;
    logic               w_any_pending;
    logic               w_grant;
    logic               w_preempt;
    logic               w_play_valid;
    logic               w_busy;
    logic               w_play_abort;

    assign w_rise        = bus.event_req & ~r_req_q & bus.ch_enable;
    assign w_any_pending = |r_pending;
    assign w_grant       = (r_state == S_OFFER) && bus.play_ready;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        w_clear = '0;
        if (w_grant) begin
            w_clear[r_code] = 1'b1;
        end
    end

    // Scan from the top so the lowest set index is the one left standing.
    always_comb begin
        w_lowest = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lowest = CODE_W'(i);
            end
        end
    end

`ifdef SOUND_PREEMPT_EN
    logic [NUM_CH-1:0] w_higher_mask;

    always_comb begin
        w_higher_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_higher_mask[i] = (CODE_W'(i) < r_code);
        end
    end

    assign w_preempt = (r_state == S_HOLD) && (|(r_pending & w_higher_mask));
`else
    assign w_preempt = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments and the async reset in the sensitivity list.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_pending) begin
                    w_next_state = S_OFFER;
                end
            end
            S_OFFER: begin
                if (bus.play_ready) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_preempt || bus.play_done || (r_timer == '0)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_play_valid = 1'b0;
        w_busy       = 1'b0;
        w_play_abort = 1'b0;
        case (r_state)
            S_OFFER: begin
                w_play_valid = 1'b1;
                w_busy       = 1'b1;
            end
            S_HOLD: begin
                w_busy       = 1'b1;
                w_play_abort = w_preempt;
            end
            default: begin
            end
        endcase
    end

    // A fresh edge on the channel being granted survives the clear (set wins).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_q   <= '0;
            r_pending <= '0;
        end else begin
            r_req_q   <= bus.event_req;
            r_pending <= (r_pending & ~w_clear) | w_rise;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code <= '0;
        end else if ((r_state == S_IDLE) && w_any_pending) begin
            r_code <= w_lowest;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_grant) begin
            r_timer <= HOLD_LOAD;
        end else if ((r_state == S_HOLD) && (r_timer != '0)) begin
            r_timer <= r_timer - TIMER_W'(1);
        end
    end

    assign bus.play_valid = w_play_valid;
    assign bus.busy       = w_busy;
    assign bus.play_abort = w_play_abort;
    assign bus.play_code  = r_code;
    assign bus.pending    = r_pending;
endmodule

// File: tb/tb_sound_request_arbiter.sv
// Self-checking bench for sound_request_arbiter: vector table, corner-case sequences and
// randomized traffic against a cycle-level ownership model of the arbiter.
module tb_sound_request_arbiter;
    localparam int NUM_CH = 8;
    localparam int HOLD   = 4;
`ifdef SOUND_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    sound_request_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

    sound_request_arbiter #(
        .NUM_CH      (NUM_CH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Model: who owns the player, whether it is still being offered, and how many
    // hold cycles remain (counting the current one).
    logic [7:0] m_prev;
    logic [7:0] m_pend;
    bit         m_owned;
    bit         m_offering;
    int         m_code;
    int         m_hold_left;

    function automatic void model_reset();
        m_prev = '0; m_pend = '0; m_owned = 0; m_offering = 0; m_code = 0; m_hold_left = 0;
    endfunction

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic bit preempt_now();
        logic [7:0] below;
        below = 8'((1 << m_code) - 1);
        return PREEMPT && m_owned && !m_offering && ((m_pend & below) != 0);
    endfunction

    function automatic void model_step(input logic [7:0] ev, input logic [7:0] en,
                                       input logic ready, input logic done);
        logic [7:0] rise;
        logic [7:0] old_pend;
        logic [7:0] clr;
        bit         cut;
        rise     = ev & ~m_prev & en;
        old_pend = m_pend;
        clr      = (m_owned && m_offering && ready) ? 8'(1 << m_code) : 8'h00;
        cut      = preempt_now();
        m_prev   = ev;
        if (!m_owned) begin
            if (old_pend != 0) begin
                m_code = lowest(old_pend); m_owned = 1; m_offering = 1;
            end
        end else if (m_offering) begin
            if (ready) begin
                m_offering = 0; m_hold_left = HOLD;
            end
        end else if (done || cut || m_hold_left == 1) begin
            m_owned = 0;
        end else begin
            m_hold_left--;
        end
        m_pend = (old_pend & ~clr) | rise;
    endfunction

    task automatic compare_model();
        check("model_valid",   32'(bus.play_valid), 32'(m_owned && m_offering));
        check("model_busy",    32'(bus.busy),       32'(m_owned));
        check("model_pending", 32'(bus.pending),    32'(m_pend));
        check("model_abort",   32'(bus.play_abort), 32'(preempt_now()));
        if (m_owned) check("model_code", 32'(bus.play_code), 32'(m_code));
    endtask

    task automatic tick(input logic [7:0] ev, input logic [7:0] en, input logic ready, input logic done);
        bus.event_req  = ev;
        bus.ch_enable  = en;
        bus.play_ready = ready;
        bus.play_done  = done;
        @(posedge clk);
        model_step(ev, en, ready, done);
        #1;
        compare_model();
    endtask

    // Runs with all lines low until the model says the arbiter is idle and empty.
    task automatic drain();
        for (int i = 0; i < 60 && (m_owned || m_pend != 0); i++) tick(8'h00, 8'hff, 1'b1, 1'b0);
        check("drain_idle", 32'(m_owned || m_pend != 0), 32'd0);
    endtask

    // Counts ticks until play_valid rises; a bound of 30 protects against a stuck DUT.
    task automatic wait_valid(input logic [7:0] ev, output int n);
        n = 0;
        do begin
            tick(ev, 8'hff, 1'b1, 1'b0);
            n++;
        end while (!bus.play_valid && n < 30);
    endtask

    typedef struct {
        logic [7:0] ev;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_code;
        logic       exp_busy;
        logic [7:0] exp_pend;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int         n;
        bit         abort_seen;
        logic [7:0] ev;
        logic [7:0] en;

        vecs[0] = '{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
        vecs[1] = '{8'h08, 1'b1, 1'b0, 3'd0, 1'b0, 8'h08};
        vecs[2] = '{8'h08, 1'b1, 1'b1, 3'd3, 1'b1, 8'h08};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h00};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h00};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h00};
        vecs[6] = '{8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h00};
        vecs[7] = '{8'h00, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00};
        vecs[8] = '{8'h00, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00};

        reset          = 1'b1;
        bus.event_req  = '0;
        bus.ch_enable  = 8'hff;
        bus.play_ready = 1'b0;
        bus.play_done  = 1'b0;
        model_reset();
        #12;
        check("reset_valid",   32'(bus.play_valid), 32'd0);
        check("reset_busy",    32'(bus.busy),       32'd0);
        check("reset_pending", 32'(bus.pending),    32'd0);
        check("reset_code",    32'(bus.play_code),  32'd0);
        check("reset_abort",   32'(bus.play_abort), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single request on channel 3, immediately accepted.
        for (int i = 0; i < 9; i++) begin
            tick(vecs[i].ev, 8'hff, vecs[i].ready, 1'b0);
            check($sformatf("vec%0d_valid", i),   32'(bus.play_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_code", i),    32'(bus.play_code),  32'(vecs[i].exp_code));
            check($sformatf("vec%0d_busy", i),    32'(bus.busy),       32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_pending", i), 32'(bus.pending),    32'(vecs[i].exp_pend));
        end

        // Channels 1 and 5 together: 1 first, 5 after hold plus one idle cycle.
        tick(8'h22, 8'hff, 1'b1, 1'b0);
        tick(8'h22, 8'hff, 1'b1, 1'b0);
        check("both_first_code", 32'(bus.play_code), 32'd1);
        tick(8'h00, 8'hff, 1'b1, 1'b0);
        check("both_keep_5", 32'(bus.pending), 32'h20);
        wait_valid(8'h00, n);
        check("both_second_delay", 32'(n), 32'd5);
        check("both_second_code", 32'(bus.play_code), 32'd5);
        drain();

        // Stalled offer on channel 4 while channel 0 rises.
        tick(8'h10, 8'hff, 1'b0, 1'b0);
        tick(8'h10, 8'hff, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick((i >= 3 && i < 6) ? 8'h11 : 8'h10, 8'hff, 1'b0, 1'b0);
        check("stall_code", 32'(bus.play_code), 32'd4);
        check("stall_valid", 32'(bus.play_valid), 32'd1);
        check("stall_pending", 32'(bus.pending), 32'h11);
        tick(8'h00, 8'hff, 1'b1, 1'b0);
        wait_valid(8'h00, n);
        check("stall_next_code", 32'(bus.play_code), 32'd0);
        drain();

        // Masked channel 2 toggling, then play_done cuts a hold on channel 7.
        for (int i = 0; i < 6; i++) tick(i[0] ? 8'h00 : 8'h04, 8'hfb, 1'b1, 1'b0);
        check("mask_pending", 32'(bus.pending), 32'd0);
        check("mask_busy", 32'(bus.busy), 32'd0);
        tick(8'h80, 8'hfb, 1'b1, 1'b0);
        tick(8'h80, 8'hfb, 1'b1, 1'b0);
        tick(8'h80, 8'hfb, 1'b1, 1'b0);
        check("done_in_hold", 32'(bus.busy && !bus.play_valid), 32'd1);
        tick(8'h00, 8'hfb, 1'b1, 1'b1);
        check("done_ends_hold", 32'(bus.busy), 32'd0);
        drain();

        // Channel 0 arrives while channel 6 holds the player.
        tick(8'h40, 8'hff, 1'b1, 1'b0);
        tick(8'h40, 8'hff, 1'b1, 1'b0);
        tick(8'h40, 8'hff, 1'b1, 1'b0);
        tick(8'h41, 8'hff, 1'b1, 1'b0);
        check("preempt_abort", 32'(bus.play_abort), 32'(PREEMPT));
        abort_seen = bus.play_abort;
        wait_valid(8'h00, n);
        check("preempt_delay", 32'(n), PREEMPT ? 32'd2 : 32'd4);
        check("preempt_code", 32'(bus.play_code), 32'd0);
        check("preempt_not_requeued", 32'(bus.pending[6]), 32'd0);
        drain();

        // Reset in the middle of an offer.
        tick(8'h08, 8'hff, 1'b0, 1'b0);
        tick(8'h08, 8'hff, 1'b0, 1'b0);
        check("offer_before_reset", 32'(bus.play_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midreset_valid",   32'(bus.play_valid), 32'd0);
        check("midreset_busy",    32'(bus.busy),       32'd0);
        check("midreset_pending", 32'(bus.pending),    32'd0);
        check("midreset_code",    32'(bus.play_code),  32'd0);
        model_reset();
        bus.event_req = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick(8'h00, 8'hff, 1'b1, 1'b0);
        check("no_replay", 32'(bus.busy || bus.pending != 0), 32'd0);

        // Randomized traffic.
        ev = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < NUM_CH; b++) begin
                if ($urandom_range(0, 7) == 0) ev[b] = ~ev[b];
                en[b] = ($urandom_range(0, 7) != 0);
            end
            tick(ev, en, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
